pc_irq_sequencer: RTL and testbench

- Parametrised program-flow unit for the jacaranda core: owns PC, flag register, return address, saved flag and interrupt entry/exit.
- Generalises the single-line interrupt of the current core to NUM_IRQ prioritised, individually masked channels with computed vectors, a pipeline stall input and configurable PC width.
- Sits between main_controller (jmp/je/ret/flag strobes) and instruction memory / regfile (bank select).

---
 rtl/jacaranda_pkg.sv | 22 ++
 rtl/irq_prio_enc.sv | 24 ++
 rtl/pc_irq_sequencer.sv | 140 ++++++++++++++
 tb/tb_pc_irq_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/jacaranda_pkg.sv
// Shared program-flow definitions for the jacaranda core: sequencer state
// encoding, default widths and interrupt vector placement.
package jacaranda_pkg;

  typedef enum logic {
    SEQ_RUN = 1'b0,
    SEQ_ISR = 1'b1
  } seq_state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_PC_W       = 8;
  localparam int DEF_NUM_IRQ    = 4;
  localparam int DEF_RESET_PC   = 0;
  localparam int DEF_VEC_BASE   = 8'h80;
  localparam int DEF_VEC_STRIDE = 4;

  // Caller truncates to the PC width, which gives the mod 2^PC_W wrap.
  function automatic int vec_addr(input int base, input int stride, input int ch);
    return base + ch * stride;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over NUM_IRQ request lines.
// Purely combinational; no backpressure.
module irq_prio_enc #(
  parameter int NUM_IRQ = 4,
  parameter int CH_W    = 2
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               vld,
  output logic [CH_W-1:0]    idx,
  output logic [NUM_IRQ-1:0] onehot
);

  always_comb begin
    idx = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = CH_W'(i);
    end
  end

  assign vld    = |req;
  assign onehot = req & (~req + NUM_IRQ'(1));

endmodule

// File: rtl/pc_irq_sequencer.sv
// PC / flag / interrupt entry-exit sequencer; state updates one cycle after strobes.
// stall freezes all state and blocks entry. Define PC_IRQ_PENDING_EN for sticky pending requests.
module pc_irq_sequencer
  import jacaranda_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PC_W       = DEF_PC_W,
  parameter int NUM_IRQ    = DEF_NUM_IRQ,
  parameter int RESET_PC   = DEF_RESET_PC,
  parameter int VEC_BASE   = DEF_VEC_BASE,
  parameter int VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               jmp_en,
  input  logic               je_en,
  input  logic               ret,
  input  logic               flag_w_en,
  input  logic               flag_d,
  input  logic [DATA_W-1:0]  rs_data,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [NUM_IRQ-1:0] irq_mask,
  output logic [PC_W-1:0]    pc,
  output logic               flag,
  output logic               in_isr,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [PC_W-1:0]    ret_addr
);

  localparam int CH_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  seq_state_t         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    ret_addr_q, ret_addr_d;
  logic               flag_q, flag_nxt;
  logic               saved_flag_q, saved_flag_d;
  logic [NUM_IRQ-1:0] ack_q, ack_d;

  logic [PC_W-1:0]    target;
  logic [PC_W-1:0]    next_pc;
  logic               next_flag;
  logic [PC_W-1:0]    vec_pc;
  logic [NUM_IRQ-1:0] irq_cand;
  logic               irq_vld;
  logic [CH_W-1:0]    irq_idx;
  logic [NUM_IRQ-1:0] irq_onehot;

`ifdef PC_IRQ_PENDING_EN
  logic [NUM_IRQ-1:0] pending_q;

  // Same-cycle requests are included so level behaviour keeps its timing.
  assign irq_cand = (pending_q | irq_req) & irq_mask;

  always_ff @(posedge clock) begin
    if (reset) pending_q <= '0;
    else       pending_q <= (pending_q | irq_req) & ~ack_d;
  end
`else
  assign irq_cand = irq_req & irq_mask;
`endif

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .CH_W    (CH_W)
  ) u_prio_enc (
    .req    (irq_cand),
    .vld    (irq_vld),
    .idx    (irq_idx),
    .onehot (irq_onehot)
  );

  assign target = PC_W'(rs_data);
  assign vec_pc = PC_W'(vec_addr(VEC_BASE, VEC_STRIDE, int'(irq_idx)));

  always_comb begin
    next_pc = pc_q + PC_W'(1);
    if (jmp_en)              next_pc = target;
    else if (je_en && flag_q) next_pc = target;
  end

  always_comb begin
    next_flag = flag_q;
    if (ret && state_q == SEQ_ISR) next_flag = saved_flag_q;
    else if (je_en)                next_flag = 1'b0;
    else if (flag_w_en)            next_flag = flag_d;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    flag_nxt     = flag_q;
    ret_addr_d   = ret_addr_q;
    saved_flag_d = saved_flag_q;
    ack_d        = '0;
    if (!stall) begin
      if (state_q == SEQ_ISR && ret) begin
        pc_d     = ret_addr_q;
        flag_nxt = saved_flag_q;
        state_d  = SEQ_RUN;
      end else if (state_q == SEQ_RUN && irq_vld) begin
        // The interrupted instruction completes; its successor is the return point.
        ret_addr_d   = next_pc;
        saved_flag_d = next_flag;
        flag_nxt     = next_flag;
        pc_d         = vec_pc;
        state_d      = SEQ_ISR;
        ack_d        = irq_onehot;
      end else begin
        pc_d     = next_pc;
        flag_nxt = next_flag;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= SEQ_RUN;
      pc_q         <= PC_W'(RESET_PC);
      flag_q       <= 1'b0;
      saved_flag_q <= 1'b0;
      ret_addr_q   <= '0;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      flag_q       <= flag_nxt;
      saved_flag_q <= saved_flag_d;
      ret_addr_q   <= ret_addr_d;
      ack_q        <= ack_d;
    end
  end

  assign pc       = pc_q;
  assign flag     = flag_q;
  assign in_isr   = (state_q == SEQ_ISR);
  assign irq_ack  = ack_q;
  assign ret_addr = ret_addr_q;

endmodule

// File: tb/tb_pc_irq_sequencer.sv
// Directed-vector bench for pc_irq_sequencer with default parameters;
// expectations adapt when PC_IRQ_PENDING_EN is defined.
module tb_pc_irq_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       stall;
  logic       jmp_en;
  logic       je_en;
  logic       ret;
  logic       flag_w_en;
  logic       flag_d;
  logic [7:0] rs_data;
  logic [3:0] irq_req;
  logic [3:0] irq_mask;
  logic [7:0] pc;
  logic       flag;
  logic       in_isr;
  logic [3:0] irq_ack;
  logic [7:0] ret_addr;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pc_irq_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .stall     (stall),
    .jmp_en    (jmp_en),
    .je_en     (je_en),
    .ret       (ret),
    .flag_w_en (flag_w_en),
    .flag_d    (flag_d),
    .rs_data   (rs_data),
    .irq_req   (irq_req),
    .irq_mask  (irq_mask),
    .pc        (pc),
    .flag      (flag),
    .in_isr    (in_isr),
    .irq_ack   (irq_ack),
    .ret_addr  (ret_addr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] e_pc, input logic e_flag,
                           input logic e_isr, input logic [3:0] e_ack);
    chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
    chk({tag, ".flag"}, 32'(flag), 32'(e_flag));
    chk({tag, ".in_isr"}, 32'(in_isr), 32'(e_isr));
    chk({tag, ".ack"}, 32'(irq_ack), 32'(e_ack));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; jmp_en = 1'b0; je_en = 1'b0; ret = 1'b0;
    flag_w_en = 1'b0; flag_d = 1'b0; rs_data = 8'h00;
    irq_req = 4'b0000; irq_mask = 4'b1111;
    tick();
    tick();
    reset = 1'b0;
    chk_state("reset", 8'h00, 1'b0, 1'b0, 4'b0000);
    chk("reset.ret_addr", 32'(ret_addr), 32'h0);

    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("free.pc", 32'(pc), 32'(i));
    end

    flag_w_en = 1'b1; flag_d = 1'b1;
    tick();
    chk_state("flagw", 8'h05, 1'b1, 1'b0, 4'b0000);
    flag_w_en = 1'b0;

    rs_data = 8'h3C; je_en = 1'b1;
    tick();
    chk_state("je_taken", 8'h3C, 1'b0, 1'b0, 4'b0000);
    tick();
    chk_state("je_not_taken", 8'h3D, 1'b0, 1'b0, 4'b0000);
    je_en = 1'b0;

    flag_w_en = 1'b1; flag_d = 1'b1;
    tick();
    chk_state("flagw2", 8'h3E, 1'b1, 1'b0, 4'b0000);
    flag_w_en = 1'b0;

    // jmp and je together: jump wins, je still clears the flag.
    rs_data = 8'h0F; jmp_en = 1'b1; je_en = 1'b1;
    tick();
    chk_state("jmp_je", 8'h0F, 1'b0, 1'b0, 4'b0000);
    jmp_en = 1'b0; je_en = 1'b0;
    tick();
    chk("seq.pc", 32'(pc), 32'h10);

    irq_req = 4'b0110;
    tick();
    chk_state("entry1", 8'h84, 1'b0, 1'b1, 4'b0010);
    chk("entry1.ret_addr", 32'(ret_addr), 32'h11);

    flag_w_en = 1'b1; flag_d = 1'b1;
    tick();
    chk_state("isr_flagw", 8'h85, 1'b1, 1'b1, 4'b0000);
    flag_w_en = 1'b0;

    ret = 1'b1;
    tick();
    chk_state("ret1", 8'h11, 1'b0, 1'b0, 4'b0000);
    ret = 1'b0;

    tick();
    chk_state("reentry", 8'h84, 1'b0, 1'b1, 4'b0010);
    chk("reentry.ret_addr", 32'(ret_addr), 32'h12);

    irq_req = 4'b0100; ret = 1'b1;
    tick();
    chk_state("ret2", 8'h12, 1'b0, 1'b0, 4'b0000);
    ret = 1'b0;
    tick();
    chk_state("entry_ch2", 8'h88, 1'b0, 1'b1, 4'b0100);
    chk("entry_ch2.ret_addr", 32'(ret_addr), 32'h13);

    irq_req = 4'b0000; ret = 1'b1;
    tick();
    chk_state("ret3", 8'h13, 1'b0, 1'b0, 4'b0000);

    tick();
    chk_state("ret_in_run", 8'h14, 1'b0, 1'b0, 4'b0000);
    ret = 1'b0;

    irq_req = 4'b1000; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state("stall", 8'h14, 1'b0, 1'b0, 4'b0000);
    end
    stall = 1'b0;
    tick();
    chk_state("entry_ch3", 8'h8C, 1'b0, 1'b1, 4'b1000);
    chk("entry_ch3.ret_addr", 32'(ret_addr), 32'h15);

    irq_req = 4'b0000; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_state("reset_isr", 8'h00, 1'b0, 1'b0, 4'b0000);
    chk("reset_isr.ret_addr", 32'(ret_addr), 32'h0);

    irq_req = 4'b0001; irq_mask = 4'b1110;
    tick();
    chk_state("masked", 8'h01, 1'b0, 1'b0, 4'b0000);
    irq_mask = 4'b1111;
    tick();
    chk_state("unmasked", 8'h80, 1'b0, 1'b1, 4'b0001);
    chk("unmasked.ret_addr", 32'(ret_addr), 32'h02);
    irq_req = 4'b0000; ret = 1'b1;
    tick();
    chk_state("ret4", 8'h02, 1'b0, 1'b0, 4'b0000);
    ret = 1'b0;

    rs_data = 8'hFE; jmp_en = 1'b1;
    tick();
    chk("wrap.fe", 32'(pc), 32'hFE);
    jmp_en = 1'b0;
    tick();
    chk("wrap.ff", 32'(pc), 32'hFF);
    tick();
    chk("wrap.00", 32'(pc), 32'h00);

    // Short request pulse on channel 3 while the handler for channel 0 runs.
    irq_req = 4'b0001;
    tick();
    chk_state("pend_entry", 8'h80, 1'b0, 1'b1, 4'b0001);
    irq_req = 4'b1000;
    tick();
    chk_state("pend_pulse", 8'h81, 1'b0, 1'b1, 4'b0000);
    irq_req = 4'b0000;
    tick();
    chk("pend_idle.pc", 32'(pc), 32'h82);
    ret = 1'b1;
    tick();
    chk_state("pend_ret", 8'h01, 1'b0, 1'b0, 4'b0000);
    ret = 1'b0;
    tick();
`ifdef PC_IRQ_PENDING_EN
    chk_state("pend_served", 8'h8C, 1'b0, 1'b1, 4'b1000);
    chk("pend_served.ret_addr", 32'(ret_addr), 32'h02);
`else
    chk_state("pulse_dropped", 8'h02, 1'b0, 1'b0, 4'b0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
